// File: rtl/lsu.sv
// lsu -- load/store unit, initiator side of a single data-RAM port.
//
// Takes one CPU load/store at a time and sequences the RAM port. The RAM has
// 1-cycle read latency and accepts whole-word writes only. Byte and halfword
// stores therefore read the word, merge the new lanes and write it back.
// Loads are lane-extracted and then sign- or zero-extended. Misaligned,
// out-of-range and bad-size requests are answered with an error and never
// touch the RAM.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/ready     request handshake (ready only while IDLE)
//   req_we/addr/size/wdata
//                       store flag, byte address, funct3 size, right-aligned data
//   resp_valid/err/rdata
//                       one-cycle registered completion; rdata is 0 unless load
//   mem_we/addr/size/wd RAM command (word-aligned address, full-word write)
//   mem_rd              RAM read data, valid the cycle after the address cycle
module lsu #(
   parameter int unsigned RAM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_size,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [2:0] {IDLE, LD_A, LD_D, ST_W, RMW_A, RMW_W} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic        req_err;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [4:0]  lane_sh;
   logic [31:0] lane_mask;
   logic [31:0] st_merged;

   // Request checks, evaluated on the incoming (not yet latched) request.
   always_comb begin
      req_err = 1'b0;
      if (req_size == 3'b011 || req_size[2:1] == 2'b11)
         req_err = 1'b1;
      if (req_size[1:0] == 2'b01 && req_addr[0])
         req_err = 1'b1;
      if (req_size == 3'b010 && req_addr[1:0] != 2'b00)
         req_err = 1'b1;
      if ({2'b00, req_addr[31:2]} >= RAM_WORDS)
         req_err = 1'b1;
   end

   // Load extraction; size_q[2] distinguishes the unsigned variants.
   always_comb begin
      ld_byte = 8'(mem_rd >> {addr_q[1:0], 3'b000});
      ld_half = 16'(mem_rd >> {addr_q[1], 4'b0000});
      case (size_q[1:0])
         2'b00:   ld_data = {{24{ld_byte[7]  & ~size_q[2]}}, ld_byte};
         2'b01:   ld_data = {{16{ld_half[15] & ~size_q[2]}}, ld_half};
         default: ld_data = mem_rd;
      endcase
   end

   // Store merge: replace only the addressed lanes of the word just read.
   always_comb begin
      lane_sh = {addr_q[1:0], 3'b000};
      case (size_q[1:0])
         2'b00:   lane_mask = 32'h0000_00FF << lane_sh;
         2'b01:   lane_mask = 32'h0000_FFFF << lane_sh;
         default: lane_mask = 32'hFFFF_FFFF;
      endcase
      st_merged = (mem_rd & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      size_d       = size_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'h0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               size_d  = req_size;
               wdata_d = req_wdata;
               we_d    = req_we;
               if (req_err) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_we) begin
                  state_d = (req_size == 3'b010) ? ST_W : RMW_A;
               end else begin
                  state_d = LD_A;
               end
            end
         end
         LD_A:  state_d = LD_D;
         LD_D: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = ld_data;
            state_d      = IDLE;
         end
         ST_W: begin
            resp_valid_d = 1'b1;
            state_d      = IDLE;
         end
         RMW_A: state_d = RMW_W;
         RMW_W: begin
            resp_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= 32'h0;
         size_q       <= 3'b000;
         wdata_q      <= 32'h0;
         we_q         <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // mem_we decodes straight from state so an async reset drops it at once.
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_we     = (state_q == ST_W) || (state_q == RMW_W);
   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_size   = size_q;
   assign mem_wd     = (state_q == RMW_W) ? st_merged : wdata_q;

   // we_q is kept for observability of the latched request; the state
   // encoding already carries the load/store distinction.
   logic unused_ok;
   assign unused_ok = we_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_size;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wd, mem_rd;
   logic [2:0]  mem_size;

   int checks = 0;
   int failures = 0;
   int we_cnt = 0;

   logic [31:0] ram [0:1023];

   lsu #(.RAM_WORDS(1024)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
      .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // RAM model: synchronous write, 1-cycle registered read.
   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr[11:2]] <= mem_wd;
         we_cnt <= we_cnt + 1;
      end
      mem_rd <= ram[mem_addr[11:2]];
   end

   // One request; returns cycles from accept edge to resp_valid (bounded).
   task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output int lat, output logic err,
                        output logic [31:0] rd);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      err = resp_err;
      rd  = resp_rdata;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b%b exp=00", resp_valid, resp_err); end
      checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
      checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_size !== 3'b000) begin failures++; $display("FAIL reset_mem got we=%b addr=%h size=%b exp 0", mem_we, mem_addr, mem_size); end
   endtask

   task automatic test_rmw_abort;
      int seen;
      ram[8] = 32'h1122_3344;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h21; req_size = 3'b000; req_wdata = 32'hAA;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL abort_in_rmw_w mem_we got=%b exp=1", mem_we); end
      #1 rst = 1'b1;
      #1;
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL abort_mem_we got=%b exp=0", mem_we); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", req_ready); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL abort_resp got=%0d exp=0", seen); end
      checks++; if (ram[8] !== 32'h1122_3344) begin failures++; $display("FAIL abort_ram got=%h exp=11223344", ram[8]); end
   endtask

   task automatic test_word;
      int lat; logic err; logic [31:0] rd;
      issue(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, lat, err, rd);
      checks++; if (lat != 2 || err !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL sw_resp got lat=%0d err=%b rd=%h exp 2/0/0", lat, err, rd); end
      issue(1'b0, 32'h10, 3'b010, 32'h0, lat, err, rd);
      checks++; if (lat != 3 || err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_resp got lat=%0d err=%b rd=%h exp 3/0/deadbeef", lat, err, rd); end
   endtask

   task automatic test_rmw;
      int lat; logic err; logic [31:0] rd;
      issue(1'b1, 32'h20, 3'b010, 32'h1122_3344, lat, err, rd);
      issue(1'b1, 32'h21, 3'b000, 32'hFFFF_FFAA, lat, err, rd);
      checks++; if (lat != 3 || err !== 1'b0) begin failures++; $display("FAIL sb_resp got lat=%0d err=%b exp 3/0", lat, err); end
      checks++; if (ram[8] !== 32'h1122_AA44) begin failures++; $display("FAIL sb_word got=%h exp=1122aa44", ram[8]); end
      issue(1'b1, 32'h22, 3'b001, 32'h0000_5566, lat, err, rd);
      checks++; if (lat != 3 || ram[8] !== 32'h5566_AA44) begin failures++; $display("FAIL sh_word got lat=%0d word=%h exp 3/5566aa44", lat, ram[8]); end
   endtask

   task automatic test_load_ext;
      logic [31:0] la [5] = '{32'h32, 32'h32, 32'h32, 32'h30, 32'h30};
      logic [2:0]  ls [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
      logic [31:0] le [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h0000_0001};
      int lat; logic err; logic [31:0] rd;
      ram[12] = 32'h80FF_7F01;
      for (int i = 0; i < 5; i++) begin
         issue(1'b0, la[i], ls[i], 32'h0, lat, err, rd);
         checks++;
         if (lat != 3 || err !== 1'b0 || rd !== le[i]) begin
            failures++;
            $display("FAIL load_ext[%0d] got lat=%0d err=%b rd=%h exp 3/0/%h", i, lat, err, rd, le[i]);
         end
      end
   endtask

   task automatic test_errors;
      logic        ew [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] ea [4] = '{32'h2, 32'h1, 32'h0, 32'h1000};
      logic [2:0]  es [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
      int lat, w0; logic err; logic [31:0] rd;
      w0 = we_cnt;
      for (int i = 0; i < 4; i++) begin
         issue(ew[i], ea[i], es[i], 32'h1234_5678, lat, err, rd);
         checks++;
         if (lat != 1 || err !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL err_req[%0d] got lat=%0d err=%b rd=%h exp 1/1/0", i, lat, err, rd);
         end
      end
      @(negedge clk);
      checks++; if (we_cnt != w0 || req_ready !== 1'b1) begin failures++; $display("FAIL err_no_write got writes=%0d ready=%b exp 0/1", we_cnt - w0, req_ready); end
   endtask

   task automatic test_back_to_back;
      int acc_cyc [4];
      logic [31:0] rds [4];
      int acc_n, rd_n, t;
      logic rdy;
      for (int i = 0; i < 4; i++) ram[i] = 32'hA000_0000 + 32'(i * 17);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h0;
      acc_n = 0; rd_n = 0; t = 0;
      while (t < 30 && !(acc_n == 4 && rd_n == 4)) begin
         rdy = req_ready;
         @(posedge clk);
         if (rdy && req_valid) begin acc_cyc[acc_n] = t; acc_n++; end
         @(negedge clk);
         if (resp_valid && rd_n < 4) begin rds[rd_n] = resp_rdata; rd_n++; end
         if (acc_n < 4) req_addr = 32'(acc_n * 4);
         else req_valid = 1'b0;
         t++;
      end
      req_valid = 1'b0;
      checks++; if (acc_n != 4 || rd_n != 4) begin failures++; $display("FAIL b2b_count got acc=%0d rd=%0d exp 4/4", acc_n, rd_n); end
      for (int i = 0; i < 4; i++) begin
         if (i < acc_n) begin
            checks++;
            if (acc_cyc[i] != i * 3) begin failures++; $display("FAIL b2b_accept[%0d] got=%0d exp=%0d", i, acc_cyc[i], i * 3); end
         end
         if (i < rd_n) begin
            checks++;
            if (rds[i] !== 32'hA000_0000 + 32'(i * 17)) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, rds[i], 32'hA000_0000 + 32'(i * 17)); end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_addr = 32'h0; req_size = 3'b000; req_wdata = 32'h0;
      test_reset();
      test_rmw_abort();
      test_word();
      test_rmw();
      test_load_ext();
      test_errors();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
